// File: rtl/composite_arbiter.sv
// -----------------------------------------------------------------------------
// composite_arbiter
//   Four-to-one merge of (meta, data-packet) stream pairs. One input port is
//   granted at a time in round-robin order. The granted port's meta word is
//   forwarded first, then its whole data packet (up to and including the beat
//   with last=1). Packets are never interleaved on the output.
//
//   FSM: IDLE -> pick a port with meta valid, scanning from rr_ptr
//        META -> forward the granted meta word until it is accepted
//        DATA -> combinational pass-through until the last beat is accepted
//
// Ports
//   clock, reset                  single clock, async active-high reset
//   io_in_metaK_{valid,ready,bits}                 per-port meta stream, K=0..3
//   io_in_dataK_{valid,ready,bits_last,bits_data,bits_keep}  per-port data
//   io_out_meta_{valid,ready,bits}                 merged meta stream
//   io_out_data_{valid,ready,bits_last,bits_data,bits_keep}  merged data
//   io_pkt_cnt, io_beat_cnt       (only with COMPOSITE_ARBITER_STATS_EN)
//
// Build option
//   COMPOSITE_ARBITER_STATS_EN : adds 32-bit packet and beat counters on the
//   output data handshake. Without it the counters and ports do not exist.
// -----------------------------------------------------------------------------

// Per-port ready gating: a port only sees the downstream ready while it holds
// the grant and the FSM is in the matching phase.
module composite_arbiter_lane (
  input  logic i_sel,
  input  logic i_meta_en,
  input  logic i_data_en,
  input  logic i_out_meta_ready,
  input  logic i_out_data_ready,
  output logic o_meta_ready,
  output logic o_data_ready
);
  assign o_meta_ready = i_sel & i_meta_en & i_out_meta_ready;
  assign o_data_ready = i_sel & i_data_en & i_out_data_ready;
endmodule

module composite_arbiter #(
  parameter int META_W = 8,
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clock,
  input  logic              reset,
`ifdef COMPOSITE_ARBITER_STATS_EN
  output logic [31:0]       io_pkt_cnt,
  output logic [31:0]       io_beat_cnt,
`endif
  input  logic              io_in_meta0_valid,
  output logic              io_in_meta0_ready,
  input  logic [META_W-1:0] io_in_meta0_bits,
  input  logic              io_in_data0_valid,
  output logic              io_in_data0_ready,
  input  logic              io_in_data0_bits_last,
  input  logic [DATA_W-1:0] io_in_data0_bits_data,
  input  logic [KEEP_W-1:0] io_in_data0_bits_keep,
  input  logic              io_in_meta1_valid,
  output logic              io_in_meta1_ready,
  input  logic [META_W-1:0] io_in_meta1_bits,
  input  logic              io_in_data1_valid,
  output logic              io_in_data1_ready,
  input  logic              io_in_data1_bits_last,
  input  logic [DATA_W-1:0] io_in_data1_bits_data,
  input  logic [KEEP_W-1:0] io_in_data1_bits_keep,
  input  logic              io_in_meta2_valid,
  output logic              io_in_meta2_ready,
  input  logic [META_W-1:0] io_in_meta2_bits,
  input  logic              io_in_data2_valid,
  output logic              io_in_data2_ready,
  input  logic              io_in_data2_bits_last,
  input  logic [DATA_W-1:0] io_in_data2_bits_data,
  input  logic [KEEP_W-1:0] io_in_data2_bits_keep,
  input  logic              io_in_meta3_valid,
  output logic              io_in_meta3_ready,
  input  logic [META_W-1:0] io_in_meta3_bits,
  input  logic              io_in_data3_valid,
  output logic              io_in_data3_ready,
  input  logic              io_in_data3_bits_last,
  input  logic [DATA_W-1:0] io_in_data3_bits_data,
  input  logic [KEEP_W-1:0] io_in_data3_bits_keep,
  output logic              io_out_meta_valid,
  input  logic              io_out_meta_ready,
  output logic [META_W-1:0] io_out_meta_bits,
  output logic              io_out_data_valid,
  input  logic              io_out_data_ready,
  output logic              io_out_data_bits_last,
  output logic [DATA_W-1:0] io_out_data_bits_data,
  output logic [KEEP_W-1:0] io_out_data_bits_keep
);

  localparam int NP = 4;

  typedef enum logic [1:0] {S_IDLE, S_META, S_DATA} state_t;

  state_t r_state;
  logic [1:0] r_idx;
  logic [1:0] r_rr_ptr;

  // Gather the scalar per-port ports into packed arrays for indexed muxing.
  logic [NP-1:0]             w_mv, w_dv, w_dl, w_mr, w_dr;
  logic [NP-1:0][META_W-1:0] w_mb;
  logic [NP-1:0][DATA_W-1:0] w_dd;
  logic [NP-1:0][KEEP_W-1:0] w_dk;

  assign w_mv = {io_in_meta3_valid, io_in_meta2_valid, io_in_meta1_valid, io_in_meta0_valid};
  assign w_mb = {io_in_meta3_bits,  io_in_meta2_bits,  io_in_meta1_bits,  io_in_meta0_bits};
  assign w_dv = {io_in_data3_valid, io_in_data2_valid, io_in_data1_valid, io_in_data0_valid};
  assign w_dl = {io_in_data3_bits_last, io_in_data2_bits_last,
                 io_in_data1_bits_last, io_in_data0_bits_last};
  assign w_dd = {io_in_data3_bits_data, io_in_data2_bits_data,
                 io_in_data1_bits_data, io_in_data0_bits_data};
  assign w_dk = {io_in_data3_bits_keep, io_in_data2_bits_keep,
                 io_in_data1_bits_keep, io_in_data0_bits_keep};

  // Round-robin scan starting at rr_ptr. Offsets are walked from the
  // farthest to the nearest so the last hit (smallest offset) wins.
  logic       w_found;
  logic [1:0] w_pick;
  always_comb begin
    logic [1:0] v_cand;
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    v_cand  = r_rr_ptr;
    for (int i = NP-1; i >= 0; i--) begin
      v_cand = r_rr_ptr + 2'(i);
      if (w_mv[v_cand]) begin
        w_found = 1'b1;
        w_pick  = v_cand;
      end
    end
  end

  logic w_meta_en, w_data_en, w_meta_hs, w_data_hs;
  assign w_meta_en = (r_state == S_META);
  assign w_data_en = (r_state == S_DATA);

  assign io_out_meta_valid     = w_meta_en & w_mv[r_idx];
  assign io_out_meta_bits      = w_mb[r_idx];
  assign io_out_data_valid     = w_data_en & w_dv[r_idx];
  assign io_out_data_bits_last = w_dl[r_idx];
  assign io_out_data_bits_data = w_dd[r_idx];
  assign io_out_data_bits_keep = w_dk[r_idx];

  assign w_meta_hs = io_out_meta_valid & io_out_meta_ready;
  assign w_data_hs = io_out_data_valid & io_out_data_ready;

  for (genvar k = 0; k < NP; k++) begin : g_lane
    composite_arbiter_lane u_lane (
      .i_sel            (r_idx == 2'(k)),
      .i_meta_en        (w_meta_en),
      .i_data_en        (w_data_en),
      .i_out_meta_ready (io_out_meta_ready),
      .i_out_data_ready (io_out_data_ready),
      .o_meta_ready     (w_mr[k]),
      .o_data_ready     (w_dr[k])
    );
  end

  assign io_in_meta0_ready = w_mr[0];
  assign io_in_meta1_ready = w_mr[1];
  assign io_in_meta2_ready = w_mr[2];
  assign io_in_meta3_ready = w_mr[3];
  assign io_in_data0_ready = w_dr[0];
  assign io_in_data1_ready = w_dr[1];
  assign io_in_data2_ready = w_dr[2];
  assign io_in_data3_ready = w_dr[3];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_rr_ptr <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_idx   <= w_pick;
          r_state <= S_META;
        end
        S_META: if (w_meta_hs) r_state <= S_DATA;
        S_DATA: if (w_data_hs && io_out_data_bits_last) begin
          // Next scan starts just past the port that was served.
          r_rr_ptr <= r_idx + 2'd1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef COMPOSITE_ARBITER_STATS_EN
  logic [31:0] r_pkt_cnt, r_beat_cnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pkt_cnt  <= 32'd0;
      r_beat_cnt <= 32'd0;
    end else if (w_data_hs) begin
      r_beat_cnt <= r_beat_cnt + 32'd1;
      if (io_out_data_bits_last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end
  assign io_pkt_cnt  = r_pkt_cnt;
  assign io_beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_composite_arbiter.sv
module tb_composite_arbiter;

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [3:0]       mv, dv, dl;
  logic [3:0][7:0]  mb;
  logic [3:0][31:0] dd;
  logic [3:0][3:0]  dk;
  logic mr0, mr1, mr2, mr3, dr0, dr1, dr2, dr3;
  logic [3:0] mr, dr;
  assign mr = {mr3, mr2, mr1, mr0};
  assign dr = {dr3, dr2, dr1, dr0};

  logic        omv, omr, odv, odr, odl;
  logic [7:0]  omb;
  logic [31:0] odd;
  logic [3:0]  odk;
`ifdef COMPOSITE_ARBITER_STATS_EN
  logic [31:0] pkt_cnt, beat_cnt;
`endif

  composite_arbiter dut (
    .clock(clock), .reset(reset),
`ifdef COMPOSITE_ARBITER_STATS_EN
    .io_pkt_cnt(pkt_cnt), .io_beat_cnt(beat_cnt),
`endif
    .io_in_meta0_valid(mv[0]), .io_in_meta0_ready(mr0), .io_in_meta0_bits(mb[0]),
    .io_in_data0_valid(dv[0]), .io_in_data0_ready(dr0), .io_in_data0_bits_last(dl[0]),
    .io_in_data0_bits_data(dd[0]), .io_in_data0_bits_keep(dk[0]),
    .io_in_meta1_valid(mv[1]), .io_in_meta1_ready(mr1), .io_in_meta1_bits(mb[1]),
    .io_in_data1_valid(dv[1]), .io_in_data1_ready(dr1), .io_in_data1_bits_last(dl[1]),
    .io_in_data1_bits_data(dd[1]), .io_in_data1_bits_keep(dk[1]),
    .io_in_meta2_valid(mv[2]), .io_in_meta2_ready(mr2), .io_in_meta2_bits(mb[2]),
    .io_in_data2_valid(dv[2]), .io_in_data2_ready(dr2), .io_in_data2_bits_last(dl[2]),
    .io_in_data2_bits_data(dd[2]), .io_in_data2_bits_keep(dk[2]),
    .io_in_meta3_valid(mv[3]), .io_in_meta3_ready(mr3), .io_in_meta3_bits(mb[3]),
    .io_in_data3_valid(dv[3]), .io_in_data3_ready(dr3), .io_in_data3_bits_last(dl[3]),
    .io_in_data3_bits_data(dd[3]), .io_in_data3_bits_keep(dk[3]),
    .io_out_meta_valid(omv), .io_out_meta_ready(omr), .io_out_meta_bits(omb),
    .io_out_data_valid(odv), .io_out_data_ready(odr), .io_out_data_bits_last(odl),
    .io_out_data_bits_data(odd), .io_out_data_bits_keep(odk)
  );

  int n_chk = 0, n_pass = 0;
  int beats_seen = 0;
  int mdl_ptr = 0, mdl_pkts = 0, mdl_beats = 0;
  bit meta_hold = 0, data_hold = 0, bp_en = 0, gap_en = 0;

  logic [7:0] mq[4][$];   // per-port driver queues
  beat_t      dq[4][$];
  logic [7:0] sm[4][$];   // staging before the model orders them
  beat_t      sb[4][$];
  logic [7:0] exp_meta[$];
  beat_t      exp_beat[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
  endtask

  task automatic add_pkt(input int p, input logic [7:0] meta, input int len,
                         input logic [31:0] base, input logic [31:0] step);
    beat_t b;
    sm[p].push_back(meta);
    for (int i = 0; i < len; i++) begin
      b.last = (i == len-1);
      b.keep = 4'($urandom);
      b.data = base + step * 32'(i);
      sb[p].push_back(b);
    end
  endtask

  // Reference: strict round-robin over ports that still have packets
  // pending, starting at the port after the last one served. Whole packets
  // go out back-to-back in that order.
  task automatic commit();
    bit found;
    int pick;
    beat_t b;
    logic [7:0] m;
    do begin
      found = 0;
      pick = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && sm[(mdl_ptr + k) % 4].size() > 0) begin
          found = 1;
          pick = (mdl_ptr + k) % 4;
        end
      end
      if (found) begin
        m = sm[pick].pop_front();
        exp_meta.push_back(m);
        mq[pick].push_back(m);
        do begin
          b = sb[pick].pop_front();
          exp_beat.push_back(b);
          dq[pick].push_back(b);
          mdl_beats++;
        end while (!b.last);
        mdl_pkts++;
        mdl_ptr = (pick + 1) % 4;
      end
    end while (found);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_meta.size() + exp_beat.size()) != 0 && t < 5000) begin
      @(posedge clock);
      t++;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    check({name, "_drain"}, 64'(exp_meta.size() + exp_beat.size()), 64'd0);
`ifdef COMPOSITE_ARBITER_STATS_EN
    check({name, "_pkt_cnt"},  64'(pkt_cnt),  64'(mdl_pkts));
    check({name, "_beat_cnt"}, 64'(beat_cnt), 64'(mdl_beats));
`endif
  endtask

  // Driver: all upstream inputs and downstream readys change 1 time unit
  // after the rising edge; handshakes are sampled at the falling edge.
  initial begin
    bit mhs[4], dhs[4];
    mv = '0; dv = '0; dl = '0; mb = '0; dd = '0; dk = '0;
    omr = 1'b1; odr = 1'b1;
    forever begin
      @(negedge clock);
      for (int p = 0; p < 4; p++) begin
        mhs[p] = mv[p] && mr[p];
        dhs[p] = dv[p] && dr[p];
      end
      @(posedge clock);
      #1;
      omr = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      odr = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int p = 0; p < 4; p++) begin
        if (reset) begin
          mv[p] = 1'b0; dv[p] = 1'b0;
          mq[p].delete(); dq[p].delete();
        end else begin
          if (mhs[p]) begin mv[p] = 1'b0; void'(mq[p].pop_front()); end
          if (dhs[p]) begin dv[p] = 1'b0; void'(dq[p].pop_front()); end
          if (!mv[p] && mq[p].size() > 0 && !meta_hold) begin
            mv[p] = 1'b1;
            mb[p] = mq[p][0];
          end
          if (!dv[p] && dq[p].size() > 0 && !data_hold &&
              (!gap_en || $urandom_range(0, 2) != 0)) begin
            dv[p] = 1'b1;
            dl[p] = dq[p][0].last;
            dk[p] = dq[p][0].keep;
            dd[p] = dq[p][0].data;
          end
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    beat_t e;
    logic [7:0] em;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (omv && omr) begin
          if (exp_meta.size() == 0) check("meta_unexpected", 64'(omb), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            em = exp_meta.pop_front();
            check("meta", 64'(omb), 64'(em));
          end
        end
        if (odv && odr) begin
          beats_seen++;
          if (exp_beat.size() == 0) check("beat_unexpected", 64'({odl, odk, odd}), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            e = exp_beat.pop_front();
            check("beat", 64'({odl, odk, odd}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] acc;
    int t;
    // Reset state
    #1;
    check("reset_outputs", 64'({omv, odv, mr, dr}), 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_outputs", 64'({omv, odv, mr, dr}), 64'd0);

    // Basic: all four ports at once, single-beat packets
    for (int p = 0; p < 4; p++) add_pkt(p, 8'(p), 1, 32'(p), 32'd0);
    commit();
    drain("basic");

    // Multi-beat: 3 beats per packet, two rounds
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) add_pkt(p, 8'({p[1:0], 6'(r)}), 3, 32'(p), 32'd0);
    commit();
    drain("multibeat");

    // Meta first, data 100 ns later
    data_hold = 1;
    for (int p = 0; p < 4; p++) add_pkt(p, 8'(8'h40 + p), 2, 32'h100 * 32'(p + 1), 32'd1);
    commit();
    acc = '0;
    repeat (10) begin @(negedge clock); acc[0] = acc[0] | odv; end
    check("metafirst_data_invalid", 64'(acc[0]), 64'd0);
    check("metafirst_port0_meta_taken", 64'(exp_meta.size()), 64'd3);
    data_hold = 0;
    drain("metafirst");

    // Data first, meta 100 ns later
    meta_hold = 1;
    for (int p = 0; p < 4; p++) add_pkt(p, 8'(8'h80 + p), 1 + p, 32'h1000 * 32'(p + 1), 32'd3);
    commit();
    acc = '0;
    repeat (10) begin @(negedge clock); acc = acc | dr; end
    check("datafirst_readys_low", 64'(acc), 64'd0);
    meta_hold = 0;
    drain("datafirst");

    // Backpressure and fairness on ports 2 and 3
    bp_en = 1; gap_en = 1;
    for (int i = 0; i < 4; i++) begin
      add_pkt(2, 8'(8'h90 + i), $urandom_range(1, 5), $urandom, 32'd1);
      add_pkt(3, 8'(8'hA0 + i), $urandom_range(1, 5), $urandom, 32'd1);
    end
    commit();
    drain("backpressure");

    // Random mix across all ports
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        add_pkt(p, 8'($urandom), $urandom_range(1, 4), $urandom, 32'($urandom));
    commit();
    drain("random");
    bp_en = 0; gap_en = 0;

    // Reset mid-packet. Serve port 2 once so rr_ptr sits at 3.
    add_pkt(2, 8'hC0, 1, 32'hC0, 32'd0);
    commit();
    drain("pre_reset");
    add_pkt(2, 8'hC1, 3, 32'hD0, 32'd1);
    commit();
    t = 0;
    begin
      int start = beats_seen;
      while (beats_seen < start + 2 && t < 200) begin @(negedge clock); t++; end
    end
    check("reset_wait_two_beats", 64'(t < 200), 64'd1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    exp_meta.delete();
    exp_beat.delete();
    #1;
    check("reset_midpkt_outputs", 64'({omv, odv, mr, dr}), 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mdl_ptr = 0; mdl_pkts = 0; mdl_beats = 0;
`ifdef COMPOSITE_ARBITER_STATS_EN
    check("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
    // Ports 1 and 3 both request: from rr_ptr=0 port 1 must win.
    add_pkt(3, 8'hE3, 2, 32'hE300, 32'd1);
    add_pkt(1, 8'hE1, 2, 32'hE100, 32'd1);
    commit();
    drain("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/composite_arbiter.md
Name: composite_arbiter

Overview:
- Four-to-one merge of meta + data stream pairs; the reverse direction of the composite router.
- Each input port K (0..3) offers one meta word per packet plus a data packet of 1..n beats terminated by last.
- The block grants one port at a time in round-robin order and forwards its meta word, then its whole data packet, to a single output pair.
- Packets are never interleaved on the output.

Parameters:
- META_W, 8, meta word width
- DATA_W, 32, data beat width
- KEEP_W, 4, keep width (DATA_W/8)

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- io_in_metaK_valid  in  1  port K meta valid (K=0..3)
- io_in_metaK_ready  out  1  port K meta ready
- io_in_metaK_bits  in  META_W  port K meta word
- io_in_dataK_valid  in  1  port K data valid
- io_in_dataK_ready  out  1  port K data ready
- io_in_dataK_bits_last  in  1  port K end of packet
- io_in_dataK_bits_data  in  DATA_W  port K beat
- io_in_dataK_bits_keep  in  KEEP_W  port K byte enables
- io_out_meta_valid / io_out_meta_ready / io_out_meta_bits  out/in/out  1/1/META_W  merged meta
- io_out_data_valid / io_out_data_ready  out/in  1/1  merged data handshake
- io_out_data_bits_last / _data / _keep  out  1/DATA_W/KEEP_W  merged beat

Behaviour:
- Clock, reset and state:
  - One clock.
  - Reset is asynchronous and active-high: state=IDLE, rr_ptr=0, grant idx=0.
  - While in reset and in IDLE, every valid and ready output is 0.
- State IDLE:
  - Scan io_in_metaK_valid starting at rr_ptr, wrapping 3->0.
  - The first valid port becomes idx (2-bit register). Next state is META.
  - If no port is valid, stay in IDLE.
  - No ready is asserted in IDLE.
- State META:
  - io_out_meta_valid = io_in_meta[idx]_valid.
  - io_out_meta_bits = io_in_meta[idx]_bits.
  - io_in_meta[idx]_ready = io_out_meta_ready. All other meta readys are 0.
  - Handshake moves the state to DATA.
- State DATA:
  - Pure combinational pass-through of valid, bits and ready between io_in_data[idx] and io_out_data.
  - All other data readys and all meta readys are 0.
  - A handshake with last=1 sets rr_ptr=idx+1 (mod 4). Next state is IDLE.
- Latency and throughput:
  - Meta valid appears 1 cycle after an input meta valid is seen in IDLE.
  - The first data beat can transfer the cycle after the meta handshake.
  - Per-packet overhead is 2 cycles (IDLE + META). Data throughput within a packet is 1 beat/cycle.
- Handshake rules:
  - A transfer happens on valid&&ready at the rising edge.
  - Outputs follow the standard valid/ready contract. Upstream valid is required to be held until ready.
- Boundary conditions:
  - Data on a non-granted port before its meta: stalled, ready=0, no loss.
  - Meta of the granted port arriving before its data: the meta is forwarded and DATA waits indefinitely.
  - Single-beat packet (last=1 on the first beat): DATA lasts 1 handshake.
  - Several ports valid at once: strict round-robin from rr_ptr, so no port is starved.
  - Output backpressure at any point: state holds and nothing is dropped.
  - Reset asserted mid-packet: return to IDLE immediately and drop the partial packet. Upstream restarts after reset.

Optional Feature:
- Macro COMPOSITE_ARBITER_STATS_EN.
- When defined:
  - Adds output io_pkt_cnt (32 bits), the count of output data handshakes with last=1.
  - Adds output io_beat_cnt (32 bits), the count of all output data handshakes.
  - Both are reset to 0 and wrap modulo 2^32.
- When undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Basic:
  - Stimulus: metas 0,1,2,3 on ports 0..3 at once; single-beat data 32'h0..32'h3 with last=1; outputs always ready.
  - Required: output meta order 0,1,2,3; data order 0,1,2,3; each output beat has last=1.
- Multi-beat:
  - Stimulus: each port sends 3 beats (last on the 3rd) with data = port number, two rounds.
  - Required: 24 output beats in groups of 3 with no interleave; port order 0,1,2,3,0,1,2,3.
- Meta first, data 100 ns later:
  - Required: META on port 0 is accepted; the output data stays invalid until port 0's data arrives; then ports 1..3 follow in order.
- Data first, meta 100 ns later:
  - Required: all data readys stay 0 until the meta arrives; then the full packets are forwarded intact.
- Backpressure and fairness:
  - Stimulus: toggle io_out_data_ready randomly while ports 2 and 3 stay continuously valid.
  - Required: grants alternate 2,3,2,3; every beat is preserved; with STATS_EN, io_pkt_cnt equals the number of packets sent.
- Reset mid-packet:
  - Stimulus: assert reset after beat 2 of a 3-beat packet.
  - Required: outputs are invalid immediately; after release the next meta on port 1 is granted from rr_ptr=0.
